// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding and
// the opcode-class codes taken from the top two opcode bits.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_FETCH_OP = 3'd1,
    ST_FETCH_LO = 3'd2,
    ST_FETCH_HI = 3'd3,
    ST_EXEC     = 3'd4
  } state_t;

  localparam logic [1:0] CLASS_NONE  = 2'b00;
  localparam logic [1:0] CLASS_IMM8  = 2'b01;
  localparam logic [1:0] CLASS_IMM16 = 2'b10;
  localparam logic [1:0] CLASS_JUMP  = 2'b11;

endpackage

// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch sequencer: reads opcode and operand bytes at
// the external PC, drives active-low PC increment/load strobes, flags EXEC.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int WordSize = 16,
  parameter int OpWidth  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WordSize-1:0] pc,
  input  logic [OpWidth-1:0]  mem_data,
  input  logic                stall,
  input  logic                taken,
  output logic                PCwe,
  output logic                PCinc,
  output logic [WordSize-1:0] PCdata,
  output logic [OpWidth-1:0]  opcode,
  output logic [WordSize-1:0] operand,
  output logic                instr_valid,
  output logic [2:0]          o_dbg_state,
  output logic [WordSize-1:0] o_dbg_op_addr
);

  state_t              r_state;
  logic [OpWidth-1:0]  r_opcode;
  logic [WordSize-1:0] r_operand;
  logic [WordSize-1:0] r_op_addr;

  state_t              w_next;
  logic [OpWidth-1:0]  w_op_next;
  logic [WordSize-1:0] w_operand_next;
  logic [WordSize-1:0] w_op_addr_next;
  logic                w_pcwe;
  logic                w_pcinc;
  logic [WordSize-1:0] w_pcdata;
  logic                w_iv;
  logic [1:0]          w_class;
  logic [1:0]          w_mem_class;

  assign w_class     = r_opcode[OpWidth-1 -: 2];
  // In FETCH_OP the opcode is not registered yet, so branch on the incoming byte.
  assign w_mem_class = mem_data[OpWidth-1 -: 2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_INIT;
      r_opcode  <= '0;
      r_operand <= '0;
      r_op_addr <= '0;
    end else begin
      r_state   <= w_next;
      r_opcode  <= w_op_next;
      r_operand <= w_operand_next;
      r_op_addr <= w_op_addr_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_op_next      = r_opcode;
    w_operand_next = r_operand;
    w_op_addr_next = r_op_addr;
    w_pcwe         = 1'b1;
    w_pcinc        = 1'b1;
    w_pcdata       = '0;
    w_iv           = 1'b0;
    case (r_state)
      ST_INIT: begin
        // PC load to zero happens even when stalled so fetch always restarts at 0.
        w_pcwe = 1'b0;
        w_next = ST_FETCH_OP;
      end
      ST_FETCH_OP: begin
        if (!stall) begin
          w_pcinc        = 1'b0;
          w_op_next      = mem_data;
          w_operand_next = '0;
          w_op_addr_next = pc;
          w_next         = (w_mem_class == CLASS_NONE) ? ST_EXEC : ST_FETCH_LO;
        end
      end
      ST_FETCH_LO: begin
        if (!stall) begin
          w_pcinc                     = 1'b0;
          w_operand_next[OpWidth-1:0] = mem_data;
          w_next = (w_class == CLASS_IMM8) ? ST_EXEC : ST_FETCH_HI;
        end
      end
      ST_FETCH_HI: begin
        if (!stall) begin
          w_pcinc                               = 1'b0;
          w_operand_next[2*OpWidth-1:OpWidth]   = mem_data;
          w_next                                = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_iv = 1'b1;
        if (!stall) begin
          if (w_class == CLASS_JUMP && taken) begin
            w_pcwe   = 1'b0;
            w_pcdata = r_operand;
          end
          w_next = ST_FETCH_OP;
        end
      end
      default: w_next = ST_INIT;
    endcase
  end

  // Reset held low must silence the INIT load strobe as well.
  assign PCwe          = w_pcwe | ~reset;
  assign PCinc         = w_pcinc | ~reset;
  assign PCdata        = reset ? w_pcdata : '0;
  assign instr_valid   = w_iv;
  assign opcode        = r_opcode;
  assign operand       = r_operand;
  assign o_dbg_state   = r_state;
  assign o_dbg_op_addr = r_op_addr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a PC/memory model around the DUT, a table of
// instructions with expected results, and a scoreboard fed per instruction.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int SBW = 41;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        taken;
  logic [15:0] pc = 16'h5555;
  logic [7:0]  mem_data;
  logic        PCwe, PCinc, instr_valid;
  logic [15:0] PCdata, operand, dbg_op_addr;
  logic [7:0]  opcode;
  logic [2:0]  dbg_state;

  logic [7:0]     mem [0:65535];
  logic [SBW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  b0, b1, b2;
    int          nbytes;
    logic        tk;
    int          stall_at;
    int          stall_len;
    logic [7:0]  exp_op;
    logic [15:0] exp_operand;
    logic        exp_jump;
  } vec_t;

  vec_t vecs[12];

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .mem_data      (mem_data),
    .stall         (stall),
    .taken         (taken),
    .PCwe          (PCwe),
    .PCinc         (PCinc),
    .PCdata        (PCdata),
    .opcode        (opcode),
    .operand       (operand),
    .instr_valid   (instr_valid),
    .o_dbg_state   (dbg_state),
    .o_dbg_op_addr (dbg_op_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_data = mem[pc];

  always @(posedge clk) begin
    if (!PCwe) pc <= PCdata;
    else if (!PCinc) pc <= pc + 16'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [SBW-1:0] e;
    if (reset === 1'b1) begin
      chk("strobe_exclusive", 32'(!PCwe && !PCinc), 32'd0);
      if (instr_valid && !stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=opcode %h required=no instruction", opcode);
        end else begin
          e = exp_q.pop_front();
          chk("sb_addr", 32'(dbg_op_addr), 32'(e[40:25]));
          chk("sb_opcode", 32'(opcode), 32'(e[24:17]));
          chk("sb_operand", 32'(operand), 32'(e[16:1]));
          chk("sb_jump", 32'(!PCwe), 32'(e[0]));
          if (e[0]) chk("sb_jump_target", 32'(PCdata), 32'(e[16:1]));
        end
      end
    end
  end

  task automatic run_vector(input vec_t v);
    int k = 0;
    int st = 0;
    int guard = 0;
    logic s, ex_inc, ex_we;
    logic [15:0] ex_data;
    exp_q.push_back({v.addr, v.exp_op, v.exp_operand, v.exp_jump});
    chk("start_pc", 32'(pc), 32'(v.addr));
    while (k <= v.nbytes && guard < 64) begin
      s = (k == v.stall_at) && (st < v.stall_len);
      stall = s;
      taken = v.tk;
      @(negedge clk);
      ex_inc  = !((k < v.nbytes) && !s);
      ex_we   = !((k == v.nbytes) && v.exp_jump && !s);
      ex_data = ex_we ? 16'h0000 : v.exp_operand;
      chk("pcinc", 32'(PCinc), 32'(ex_inc));
      chk("pcwe", 32'(PCwe), 32'(ex_we));
      chk("pcdata", 32'(PCdata), 32'(ex_data));
      chk("instr_valid", 32'(instr_valid), 32'(k == v.nbytes));
      if (s) st++;
      else k++;
      guard++;
      @(posedge clk);
      #1;
    end
    if (guard >= 64) chk("vector_timeout", 32'd1, 32'd0);
    stall = 1'b0;
    taken = 1'b0;
  endtask

  task automatic reset_cycle(input logic stall_in_init);
    reset = 1'b0;
    #1;
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_operand", 32'(operand), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_pcwe", 32'(PCwe), 32'd1);
    chk("rst_pcinc", 32'(PCinc), 32'd1);
    chk("rst_pcdata", 32'(PCdata), 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_pcwe", 32'(PCwe), 32'd1);
    reset = 1'b1;
    stall = stall_in_init;
    @(negedge clk);
    chk("init_state", 32'(dbg_state), 32'(ST_INIT));
    chk("init_pcwe", 32'(PCwe), 32'd0);
    chk("init_pcinc", 32'(PCinc), 32'd1);
    chk("init_pcdata", 32'(PCdata), 32'd0);
    @(posedge clk);
    #1;
    stall = 1'b0;
    chk("init_pc_loaded", 32'(pc), 32'd0);
    chk("after_init_state", 32'(dbg_state), 32'(ST_FETCH_OP));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t z;
    logic [15:0] a;
    logic [7:0] b;
    reset = 1'b0;
    stall = 1'b0;
    taken = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    //          addr     b0     b1     b2   n  tk  s_at s_len op     operand   jmp
    vecs[0]  = '{16'h0000, 8'h12, 8'h00, 8'h00, 1, 1'b0, -1, 0, 8'h12, 16'h0000, 1'b0};
    vecs[1]  = '{16'h0001, 8'h40, 8'h2A, 8'h00, 2, 1'b0, -1, 0, 8'h40, 16'h002A, 1'b0};
    vecs[2]  = '{16'h0003, 8'h7F, 8'hFF, 8'h00, 2, 1'b1,  2, 2, 8'h7F, 16'h00FF, 1'b0};
    vecs[3]  = '{16'h0005, 8'h80, 8'hCD, 8'hAB, 3, 1'b0,  2, 3, 8'h80, 16'hABCD, 1'b0};
    vecs[4]  = '{16'h0008, 8'hC0, 8'h0C, 8'h00, 3, 1'b0, -1, 0, 8'hC0, 16'h000C, 1'b0};
    vecs[5]  = '{16'h000B, 8'hC5, 8'h34, 8'h12, 3, 1'b1, -1, 0, 8'hC5, 16'h1234, 1'b1};
    vecs[6]  = '{16'h1234, 8'h3F, 8'h00, 8'h00, 1, 1'b1, -1, 0, 8'h3F, 16'h0000, 1'b0};
    vecs[7]  = '{16'h1235, 8'h41, 8'h55, 8'h00, 2, 1'b1, -1, 0, 8'h41, 16'h0055, 1'b0};
    vecs[8]  = '{16'h1237, 8'hBF, 8'h78, 8'h56, 3, 1'b1,  0, 1, 8'hBF, 16'h5678, 1'b0};
    vecs[9]  = '{16'h123A, 8'hC1, 8'hFE, 8'hFF, 3, 1'b1, -1, 0, 8'hC1, 16'hFFFE, 1'b1};
    vecs[10] = '{16'hFFFE, 8'h81, 8'hEF, 8'h12, 3, 1'b0, -1, 0, 8'h81, 16'h12EF, 1'b0};
    vecs[11] = '{16'h0001, 8'h40, 8'h2A, 8'h00, 2, 1'b0, -1, 0, 8'h40, 16'h002A, 1'b0};

    // All-zero memory: one-byte instructions alternating FETCH_OP/EXEC.
    reset_cycle(1'b0);
    for (int i = 0; i < 3; i++) begin
      z = '{16'(i), 8'h00, 8'h00, 8'h00, 1, 1'b0, -1, 0, 8'h00, 16'h0000, 1'b0};
      run_vector(z);
    end

    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < vecs[i].nbytes; j++) begin
        a = vecs[i].addr + 16'(j);
        b = (j == 0) ? vecs[i].b0 : (j == 1) ? vecs[i].b1 : vecs[i].b2;
        mem[a] = b;
      end
    end
    reset_cycle(1'b0);
    for (int i = 0; i < 12; i++) run_vector(vecs[i]);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset arriving in FETCH_LO of 7F FF at 0003, with stall held through INIT.
    chk("mid_start_pc", 32'(pc), 32'h0003);
    exp_q.push_back({16'h0003, 8'h7F, 16'h00FF, 1'b0});
    @(posedge clk);
    #1;
    chk("mid_state_lo", 32'(dbg_state), 32'(ST_FETCH_LO));
    chk("mid_opcode", 32'(opcode), 32'h7F);
    reset_cycle(1'b1);
    run_vector(vecs[0]);
    chk("queue_drained_end", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter WordSize, default 16, SHALL set the program-counter and operand width.
REQ-002 Parameter OpWidth, default 8, SHALL set the memory byte and opcode width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 pc  input  WordSize  SHALL be the current program-counter value, driving the instruction-memory address.
REQ-006 mem_data  input  OpWidth  SHALL be the instruction-memory byte at address pc, valid in the same cycle.
REQ-007 stall  input  1  SHALL freeze the sequencer when high.
REQ-008 taken  input  1  SHALL be the jump condition, sampled only in EXEC.
REQ-009 PCwe  output  1  SHALL be the active-low program-counter load strobe.
REQ-010 PCinc  output  1  SHALL be the active-low program-counter increment strobe.
REQ-011 PCdata  output  WordSize  SHALL be the program-counter load value.
REQ-012 opcode  output  OpWidth  SHALL be the registered current opcode.
REQ-013 operand  output  WordSize  SHALL be the registered assembled operand.
REQ-014 instr_valid  output  1  SHALL be high while opcode/operand are complete (EXEC).

Function
REQ-015 States: INIT, FETCH_OP, FETCH_LO, FETCH_HI, EXEC.
REQ-016 Opcode class = opcode[OpWidth-1:OpWidth-2]: 00 one byte, 01 8-bit operand, 10 16-bit operand, 11 16-bit jump target.
REQ-017 INIT: PCwe=0, PCdata=0, PCinc=1; next FETCH_OP.
REQ-018 FETCH_OP: capture mem_data into opcode; clear operand to 0; PCinc=0; next EXEC if class 00, else FETCH_LO.
REQ-019 FETCH_LO: capture mem_data into operand[7:0]; PCinc=0; next EXEC if class 01, else FETCH_HI.
REQ-020 FETCH_HI: capture mem_data into operand[15:8]; PCinc=0; next EXEC.
REQ-021 EXEC: instr_valid=1; if class 11 and taken=1 then PCwe=0, PCdata=operand; next FETCH_OP.
REQ-022 PCwe and PCinc SHALL never both be 0 in any cycle.
REQ-023 PCwe, PCinc and instr_valid SHALL be combinational functions of state, class, taken and stall only; PCdata SHALL be 0 outside jump/INIT cycles.
REQ-024 stall=1: state, opcode and operand hold; PCwe=PCinc=1; instr_valid holds its state-derived value.
REQ-025 Instruction latency: 1 + operand-byte count fetch cycles, then exactly one unstalled EXEC cycle.
REQ-026 PC wrap FFFF->0000 mid-instruction SHALL be transparent; bytes are taken from whatever pc presents.
REQ-027 taken SHALL be ignored in all states except EXEC and for classes 00-10.

Reset
REQ-028 reset low SHALL immediately force state INIT, opcode=0, operand=0, instr_valid=0, PCwe=1, PCinc=1.
REQ-029 Reset mid-instruction SHALL discard the partial instruction; no PC strobe issues while reset is low.
REQ-030 First cycle after release SHALL be INIT, loading PC with 0 regardless of stall.

Structure
REQ-031 Shared package SHALL hold the state encoding and the four opcode-class constants.
REQ-032 Single module; no sub-module.

Verification
REQ-033 Reset release, mem all 0x00 -> INIT cycle PCwe=0 PCdata=0; then alternating FETCH_OP/EXEC, PCinc low once per instruction.
REQ-034 Bytes 0x40,0x2A -> opcode 0x40, operand 0x002A, instr_valid one cycle, two PCinc pulses.
REQ-035 Bytes 0xC0,0x34,0x12 with taken=1 -> operand 0x1234, EXEC PCwe=0 PCdata=0x1234; taken=0 -> PCwe stays 1.
REQ-036 Bytes 0x80,0xCD,0xAB, stall high 3 cycles during FETCH_HI -> no strobes while stalled, final operand 0xABCD.
REQ-037 reset pulsed low during FETCH_LO -> outputs zeroed immediately, INIT follows, next opcode fetched from PC 0.
REQ-038 Class-10 instruction starting at pc 0xFFFE -> bytes from FFFE, FFFF, 0000 assembled correctly.
